decoder_nto2n_seq: RTL and testbench
====================================

Name: decoder_nto2n_seq

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with enable, input-valid qualification and a selectable output polarity.
- Adds a self-timed scan mode: a one-hot output walks through all 2^N lines with a programmable dwell, emitting a frame pulse on each wrap.
- Used as the row/digit-select driver for multiplexed displays and as a general address-to-select decoder in larger datapaths.

Parameters:
- N, 3, select input width; output width is 2^N (N = 1..6).
- DWELL, 4, clock cycles each line is held active in scan mode (>= 1).
- ACTIVE_LOW, 0, 0 = selected line driven 1 and others 0; 1 = bitwise inverted outputs.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  block enable; 0 blanks output and freezes scan state
- mode  input  1  0 = direct decode, 1 = scan
- din  input  N  select value for direct decode
- din_valid  input  1  din qualifier, used only in direct mode
- dout  output  2^N  registered select lines, polarity per ACTIVE_LOW
- dout_valid  output  1  one-cycle pulse: new direct decode result on dout
- scan_idx  output  N  index of the currently active line in scan mode
- frame  output  1  one-cycle pulse when scan_idx wraps from 2^N-1 to 0

Behaviour:
- Polarity:
  - "Blank" means all lines inactive: dout = 0 when ACTIVE_LOW = 0, all ones when ACTIVE_LOW = 1.
  - "Line k active" means the one-hot value 1<<k, inverted when ACTIVE_LOW = 1.
- Reset (rst = 1 at a rising edge), overriding every other input, including mid-scan:
  - dout = blank, dout_valid = 0, frame = 0, scan_idx = 0.
  - Dwell counter = 0, state = IDLE.
- State machine, evaluated every cycle:
  - IDLE: entered on reset or whenever en = 0. Goes to DIRECT if en & !mode, to SCAN if en & mode.
  - DIRECT: stays while en & !mode. Goes to SCAN if en & mode. Goes to IDLE if !en.
  - SCAN: stays while en & mode. Goes to DIRECT if en & !mode. Goes to IDLE if !en.
- Direct mode:
  - Latency is 1 cycle: if en & !mode & din_valid at edge t, dout = line din active and dout_valid = 1 after edge t.
  - dout holds its last decoded value until the next valid input.
  - dout_valid is 1 for exactly one cycle per accepted input; back-to-back valids produce back-to-back pulses.
  - din_valid = 0 leaves dout unchanged and drives dout_valid = 0.
- Scan mode:
  - On the edge that enters SCAN: scan_idx = 0, dwell counter = 0, dout = line 0 active.
  - Each following edge while in SCAN:
    - If dwell counter < DWELL-1, increment it.
    - Otherwise clear the dwell counter and advance scan_idx = (scan_idx+1) mod 2^N; dout follows the new index on the same edge.
  - frame = 1 for exactly the one cycle after the edge at which scan_idx goes 2^N-1 -> 0; 0 otherwise.
  - din and din_valid are ignored; dout_valid stays 0.
  - DWELL = 1 advances one line every cycle.
  - Dwell counter width is $clog2(DWELL)+1, with no overflow for any legal DWELL.
- en = 0 (from any state):
  - Next edge: dout = blank, dout_valid = 0, frame = 0.
  - scan_idx and the dwell counter hold their values, so scan_idx remains observable.
  - Re-enabling in scan mode passes through IDLE, so the scan restarts at index 0.
- Mode change while enabled:
  - SCAN -> DIRECT: dout = blank on the switching edge unless din_valid is also 1 on that edge, in which case the decode is applied. scan_idx is held.
  - DIRECT -> SCAN: restart at index 0 as above. A din_valid on that edge is dropped.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset / polarity: N=3, ACTIVE_LOW=0, assert rst for 2 cycles -> dout=8'h00, dout_valid=0, scan_idx=0, frame=0. Repeat with ACTIVE_LOW=1 -> dout=8'hFF.
- Direct sweep: mode=0, en=1, din=0..7 on consecutive cycles with din_valid=1 -> one cycle later dout=01,02,04,...,80 and dout_valid held high for 8 cycles. Then din_valid=0 with din=5 -> dout stays 8'h80, dout_valid=0.
- Scan timing: N=3, DWELL=4, mode=1, en=1 -> dout=01 for 4 cycles, then 02, ..., 80. frame pulses once, 32 cycles after scan entry, as dout returns to 01. Repeat with DWELL=1 -> index advances every cycle and frame has an 8-cycle period.
- Freeze/blank: mid-scan at scan_idx=5, drop en for 3 cycles -> dout=00 and scan_idx=5 held. Re-assert en -> dout=01, scan_idx=0.
- Mode switch collision: in scan at scan_idx=3, set mode=0 with din=6 and din_valid=1 on the same cycle -> next cycle dout=8'h40, dout_valid=1, no frame pulse.
- Reset mid-operation: assert rst during scan at scan_idx=6, dwell counter=2, with din_valid=1 -> all outputs at reset values the next cycle. After rst deasserts with mode=1, en=1, the scan restarts at line 0.

Source files
------------

// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_nto2n_seq
// Purpose  : Registered N-to-2^N one-hot decoder with enable, input-valid
//            qualification and selectable output polarity, plus a self-timed
//            scan mode that walks a one-hot line across all 2^N outputs with a
//            programmable dwell and pulses 'frame' on every wrap.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous reset, active-high
//            en         - block enable; 0 blanks dout and freezes scan state
//            mode       - 0 = direct decode, 1 = scan
//            din        - select value for direct decode (N bits)
//            din_valid  - din qualifier (direct mode only)
//            dout       - registered select lines (2^N bits), polarity per
//                         ACTIVE_LOW
//            dout_valid - one-cycle pulse per accepted direct decode
//            scan_idx   - currently active line index in scan mode
//            frame      - one-cycle pulse when scan_idx wraps to 0
// Revision : 1.0 - initial release
// ============================================================================
module decoder_nto2n_seq #(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        din,
  input  logic                din_valid,
  output logic [(1<<N)-1:0]   dout,
  output logic                dout_valid,
  output logic [N-1:0]        scan_idx,
  output logic                frame
);

  localparam int c_w  = 1 << N;
  localparam int c_cw = $clog2(DWELL) + 1;

  // XOR mask that turns an active-high one-hot into the requested polarity;
  // it is also exactly the "all lines inactive" pattern.
  localparam logic [c_w-1:0]  c_blank = (ACTIVE_LOW != 0) ? {c_w{1'b1}} : {c_w{1'b0}};
  localparam logic [c_cw-1:0] c_dmax  = c_cw'(DWELL - 1);
  localparam logic [N-1:0]    c_last  = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_n;
  logic [c_w-1:0]  w_dout_n;
  logic            w_dv_n;
  logic            w_frame_n;
  logic [N-1:0]    w_idx_n;

  function automatic logic [c_w-1:0] line_sel(input logic [N-1:0] k);
    return (c_w'(1) << k) ^ c_blank;
  endfunction

  // Next-state and next-output logic. Every output is registered below, so
  // nothing here reaches a port combinationally.
  always_comb begin
    w_state_n = r_state;
    w_dout_n  = dout;
    w_dv_n    = 1'b0;
    w_frame_n = 1'b0;
    w_idx_n   = scan_idx;
    w_cnt_n   = r_cnt;

    if (!en) begin
      // Blank the lines but keep scan_idx/dwell visible and frozen.
      w_state_n = IDLE;
      w_dout_n  = c_blank;
    end else if (!mode) begin
      w_state_n = DIRECT;
      if (din_valid) begin
        w_dout_n = line_sel(din);
        w_dv_n   = 1'b1;
      end else if (r_state == SCAN) begin
        // Leaving scan without a fresh decode: do not leave a stale scan line lit.
        w_dout_n = c_blank;
      end
    end else begin
      w_state_n = SCAN;
      if (r_state != SCAN) begin
        // Any entry into scan (from IDLE or DIRECT) restarts at line 0.
        w_idx_n  = '0;
        w_cnt_n  = '0;
        w_dout_n = line_sel(N'(0));
      end else if (r_cnt < c_dmax) begin
        w_cnt_n = r_cnt + c_cw'(1);
      end else begin
        w_cnt_n   = '0;
        w_idx_n   = scan_idx + N'(1);
        w_dout_n  = line_sel(w_idx_n);
        w_frame_n = (scan_idx == c_last);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      dout       <= c_blank;
      dout_valid <= 1'b0;
      frame      <= 1'b0;
      scan_idx   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      dout       <= w_dout_n;
      dout_valid <= w_dv_n;
      frame      <= w_frame_n;
      scan_idx   <= w_idx_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_nto2n_seq
// Purpose  : Directed self-checking bench for decoder_nto2n_seq. Three
//            instances share one stimulus: (DWELL=4, active-high),
//            (DWELL=4, active-low) and (DWELL=1, active-high).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_nto2n_seq;

  logic       clk = 1'b0;
  logic       rst, en, mode, din_valid;
  logic [2:0] din;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_dv, b_dv, c_dv;
  logic [2:0] a_idx, b_idx, c_idx;
  logic       a_frame, b_frame, c_frame;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.N(3), .DWELL(4), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
    .dout(a_dout), .dout_valid(a_dv), .scan_idx(a_idx), .frame(a_frame));

  decoder_nto2n_seq #(.N(3), .DWELL(4), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
    .dout(b_dout), .dout_valid(b_dv), .scan_idx(b_idx), .frame(b_frame));

  decoder_nto2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
    .dout(c_dout), .dout_valid(c_dv), .scan_idx(c_idx), .frame(c_frame));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] e;
    int         ei;

    rst = 1'b1; en = 1'b0; mode = 1'b0; din = 3'd0; din_valid = 1'b0;

    // Reset / polarity
    tick_n(2);
    chk("rst_a_dout",  {24'd0, a_dout}, 32'h00);
    chk("rst_b_dout",  {24'd0, b_dout}, 32'hFF);
    chk("rst_a_dv",    {31'd0, a_dv},    0);
    chk("rst_a_idx",   {29'd0, a_idx},   0);
    chk("rst_a_frame", {31'd0, a_frame}, 0);

    // Direct sweep, back-to-back valids
    rst = 1'b0; en = 1'b1; mode = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 3'(i);
      tick();
      e = 8'h01 << i;
      chk("dir_a_dout", {24'd0, a_dout}, {24'd0, e});
      chk("dir_b_dout", {24'd0, b_dout}, {24'd0, ~e});
      chk("dir_a_dv",   {31'd0, a_dv},   1);
    end
    din_valid = 1'b0; din = 3'd5;
    tick();
    chk("hold_a_dout", {24'd0, a_dout}, 32'h80);
    chk("hold_a_dv",   {31'd0, a_dv},   0);
    tick();
    chk("hold2_a_dout", {24'd0, a_dout}, 32'h80);

    // Scan timing, DWELL=4 (a,b) and DWELL=1 (c); k counts edges from entry
    mode = 1'b1;
    for (int k = 0; k < 36; k++) begin
      tick();
      ei = (k / 4) % 8;
      e  = 8'h01 << ei;
      chk("scan_a_dout",  {24'd0, a_dout},  {24'd0, e});
      chk("scan_b_dout",  {24'd0, b_dout},  {24'd0, ~e});
      chk("scan_a_idx",   {29'd0, a_idx},   ei);
      chk("scan_a_frame", {31'd0, a_frame}, (k == 32) ? 1 : 0);
      chk("scan_a_dv",    {31'd0, a_dv},    0);
      e = 8'h01 << (k % 8);
      chk("scan_c_dout",  {24'd0, c_dout},  {24'd0, e});
      chk("scan_c_frame", {31'd0, c_frame}, (k > 0 && (k % 8) == 0) ? 1 : 0);
    end

    // Freeze / blank mid-scan at index 5
    en = 1'b0; tick();
    en = 1'b1; tick();           // re-entry, k=0
    chk("reent_a_dout", {24'd0, a_dout}, 32'h01);
    tick_n(21);                  // k=21 -> index 5
    chk("pre_frz_idx", {29'd0, a_idx}, 5);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_a_dout",  {24'd0, a_dout},  32'h00);
      chk("frz_b_dout",  {24'd0, b_dout},  32'hFF);
      chk("frz_a_idx",   {29'd0, a_idx},   5);
      chk("frz_a_frame", {31'd0, a_frame}, 0);
    end
    en = 1'b1;
    tick();
    chk("unfrz_a_dout", {24'd0, a_dout}, 32'h01);
    chk("unfrz_a_idx",  {29'd0, a_idx},  0);

    // Mode switch collision at index 3
    tick_n(12);                  // k=12 -> index 3
    chk("pre_sw_idx", {29'd0, a_idx}, 3);
    mode = 1'b0; din = 3'd6; din_valid = 1'b1;
    tick();
    chk("sw_a_dout",  {24'd0, a_dout},  32'h40);
    chk("sw_a_dv",    {31'd0, a_dv},    1);
    chk("sw_a_frame", {31'd0, a_frame}, 0);
    chk("sw_a_idx",   {29'd0, a_idx},   3);
    chk("sw_c_dout",  {24'd0, c_dout},  32'h40);

    // DIRECT -> SCAN drops a concurrent valid
    mode = 1'b1; din = 3'd2; din_valid = 1'b1;
    tick();
    chk("d2s_a_dout", {24'd0, a_dout}, 32'h01);
    chk("d2s_a_dv",   {31'd0, a_dv},   0);
    // SCAN -> DIRECT without valid blanks
    mode = 1'b0; din_valid = 1'b0;
    tick();
    chk("s2d_a_dout", {24'd0, a_dout}, 32'h00);
    chk("s2d_b_dout", {24'd0, b_dout}, 32'hFF);
    chk("s2d_a_dv",   {31'd0, a_dv},   0);

    // Reset mid-scan at index 6, dwell 2
    mode = 1'b1;
    tick();                      // entry, k=0
    tick_n(26);                  // k=26 -> index 6, dwell 2
    chk("pre_rst_idx", {29'd0, a_idx}, 6);
    din_valid = 1'b1; rst = 1'b1;
    tick();
    chk("mrst_a_dout",  {24'd0, a_dout},  32'h00);
    chk("mrst_b_dout",  {24'd0, b_dout},  32'hFF);
    chk("mrst_a_idx",   {29'd0, a_idx},   0);
    chk("mrst_a_dv",    {31'd0, a_dv},    0);
    chk("mrst_a_frame", {31'd0, a_frame}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_dout", {24'd0, a_dout}, 32'h01);
    chk("post_rst_idx",  {29'd0, a_idx},  0);
    chk("post_rst_dv",   {31'd0, a_dv},   0);
    tick_n(3);
    chk("post_rst_dwell", {24'd0, a_dout}, 32'h01);
    tick();
    chk("post_rst_adv", {24'd0, a_dout}, 32'h02);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
